read_out: RTL and testbench

- Reader counterpart of the output write stage: fetches quantized result rows back out of output SRAMs a/b/c and streams them to a downstream consumer (host DMA / checker) over a valid/ready interface.
- Mapping mirrors the write side. data_set 0 yields 16 rows: indices 0..7 come from SRAM a at address idx; indices 8..15 come from SRAM b at address idx-8. data_set 1 yields 8 rows from SRAM c at address idx.
- A 2-entry buffer absorbs the fixed SRAM read latency so backpressure never drops a row.

---
 rtl/read_out_pkg.sv | 33 +++
 rtl/read_out_row_skid_fifo.sv | 43 ++++
 rtl/read_out.sv | 200 ++++++++++++++++++++
 tb/tb_read_out.sv | 317 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/read_out_pkg.sv
// Shared definitions for the read_out block: default geometry, job
// selector encodings, row counts, FSM states and SRAM source tags.
package read_out_pkg;

  localparam int ARRAY_SIZE_DEF        = 8;
  localparam int OUTPUT_DATA_WIDTH_DEF = 16;
  localparam int ADDR_WIDTH_DEF        = 6;

  localparam logic [1:0] DS_AB = 2'd0;
  localparam logic [1:0] DS_C  = 2'd1;

  localparam int ROWS_AB = 16;
  localparam int ROWS_C  = 8;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_e;

  typedef enum logic [1:0] {
    SRC_A = 2'd0,
    SRC_B = 2'd1,
    SRC_C = 2'd2
  } src_e;

  // Only the two job selectors with a defined row mapping are legal.
  function automatic logic ds_legal(input logic [1:0] ds);
    return (ds == DS_AB) || (ds == DS_C);
  endfunction

endpackage

// File: rtl/read_out_row_skid_fifo.sv
// Two-entry FIFO holding {last, index, data} rows between the SRAM read
// port and the output handshake. Head entry drives the outputs directly.
module read_out_row_skid_fifo #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         srst,
  input  logic         push,
  input  logic [W-1:0] push_data,
  input  logic         pop,
  output logic [W-1:0] head,
  output logic [1:0]   count
);

  logic [W-1:0] mem [2];
  logic         wr_ptr;
  logic         rd_ptr;

  assign head = mem[rd_ptr];

  // Storage, pointers and occupancy; push and pop may coincide at any fill.
  always_ff @(posedge clk) begin
    if (srst) begin
      mem[0] <= '0;
      mem[1] <= '0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= ~wr_ptr;
      end
      if (pop) rd_ptr <= ~rd_ptr;
      case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/read_out.sv
// read_out: streams quantized result rows from output SRAMs a/b/c to a
// valid/ready consumer. data_set 0 -> rows 0..7 from a, 8..15 from b;
// data_set 1 -> rows 0..7 from c. Optional stall counter is enabled with
// the macro READ_OUT_STALL_CNT_EN.
module read_out
  import read_out_pkg::*;
#(
  parameter int ARRAY_SIZE        = ARRAY_SIZE_DEF,
  parameter int OUTPUT_DATA_WIDTH = OUTPUT_DATA_WIDTH_DEF,
  parameter int ADDR_WIDTH        = ADDR_WIDTH_DEF
) (
  input  logic                                    clk,
  input  logic                                    srst,
  input  logic                                    start,
  input  logic [1:0]                              data_set,
  output logic [ADDR_WIDTH-1:0]                   sram_raddr_a,
  input  logic [ARRAY_SIZE*OUTPUT_DATA_WIDTH-1:0] sram_rdata_a,
  output logic [ADDR_WIDTH-1:0]                   sram_raddr_b,
  input  logic [ARRAY_SIZE*OUTPUT_DATA_WIDTH-1:0] sram_rdata_b,
  output logic [ADDR_WIDTH-1:0]                   sram_raddr_c,
  input  logic [ARRAY_SIZE*OUTPUT_DATA_WIDTH-1:0] sram_rdata_c,
  output logic                                    out_valid,
  input  logic                                    out_ready,
  output logic [ARRAY_SIZE*OUTPUT_DATA_WIDTH-1:0] out_data,
  output logic [ADDR_WIDTH-1:0]                   out_index,
  output logic                                    out_last,
  output logic                                    busy,
  output logic                                    done,
  output logic                                    err
`ifdef READ_OUT_STALL_CNT_EN
  ,
  output logic [15:0]                             stall_cnt
`endif
);

  localparam int DW = ARRAY_SIZE * OUTPUT_DATA_WIDTH;
  localparam int EW = DW + ADDR_WIDTH + 1;

  state_e                state;
  logic [ADDR_WIDTH-1:0] idx;
  logic [ADDR_WIDTH-1:0] last_row;
  logic                  job_c;

  // Read issued last cycle; its data is on the selected rdata bus now.
  logic                  inflight;
  src_e                  infl_src;
  logic [ADDR_WIDTH-1:0] infl_idx;
  logic                  infl_last;

  logic [1:0]            count;
  logic                  pop;
  logic [2:0]            occ;
  logic                  can_issue;
  logic                  start_ok;

  logic                  issue_go;
  logic                  issue_c;
  logic                  issue_last;
  logic [ADDR_WIDTH-1:0] issue_idx;
  logic [ADDR_WIDTH-1:0] issue_lastrow;
  src_e                  issue_src;

  logic [DW-1:0]         rdata;
  logic [EW-1:0]         head;

  assign out_valid = (count != 2'd0);
  assign pop       = out_valid & out_ready;
  assign {out_last, out_index, out_data} = head;

  // A slot freed by this cycle's pop is reusable immediately, which keeps
  // one row per cycle flowing while never overfilling the buffer.
  assign occ       = {1'b0, count} + {2'b00, inflight} - {2'b00, pop};
  assign can_issue = (occ < 3'd2);
  assign start_ok  = (state == S_IDLE) && start && ds_legal(data_set);

  // Read issue decision: row 0 goes out with the accepted start so the
  // first row is visible two cycles later.
  always_comb begin
    issue_go      = 1'b0;
    issue_idx     = idx;
    issue_c       = job_c;
    issue_lastrow = last_row;
    if (state == S_IDLE) begin
      issue_idx     = '0;
      issue_c       = (data_set == DS_C);
      issue_lastrow = issue_c ? ADDR_WIDTH'(ROWS_C - 1) : ADDR_WIDTH'(ROWS_AB - 1);
      issue_go      = start_ok;
    end else if (state == S_ISSUE) begin
      issue_go = can_issue;
    end
    issue_last = (issue_idx == issue_lastrow);
    if (issue_c)                                     issue_src = SRC_C;
    else if (issue_idx < ADDR_WIDTH'(ARRAY_SIZE))    issue_src = SRC_A;
    else                                             issue_src = SRC_B;
  end

  // SRAM address registers and in-flight tag; idle ports park at 0.
  always_ff @(posedge clk) begin
    if (srst) begin
      sram_raddr_a <= '0;
      sram_raddr_b <= '0;
      sram_raddr_c <= '0;
      inflight     <= 1'b0;
      infl_src     <= SRC_A;
      infl_idx     <= '0;
      infl_last    <= 1'b0;
    end else begin
      sram_raddr_a <= '0;
      sram_raddr_b <= '0;
      sram_raddr_c <= '0;
      inflight     <= issue_go;
      infl_src     <= issue_src;
      infl_idx     <= issue_idx;
      infl_last    <= issue_last;
      if (issue_go) begin
        case (issue_src)
          SRC_A:   sram_raddr_a <= issue_idx;
          SRC_B:   sram_raddr_b <= issue_idx - ADDR_WIDTH'(ARRAY_SIZE);
          default: sram_raddr_c <= issue_idx;
        endcase
      end
    end
  end

  // Return data select for the in-flight read.
  always_comb begin
    rdata = sram_rdata_a;
    case (infl_src)
      SRC_B:   rdata = sram_rdata_b;
      SRC_C:   rdata = sram_rdata_c;
      default: rdata = sram_rdata_a;
    endcase
  end

  read_out_row_skid_fifo #(.W(EW)) u_fifo (
    .clk       (clk),
    .srst      (srst),
    .push      (inflight),
    .push_data ({infl_last, infl_idx, rdata}),
    .pop       (pop),
    .head      (head),
    .count     (count)
  );

  // Job control FSM with registered busy/done/err.
  always_ff @(posedge clk) begin
    if (srst) begin
      state    <= S_IDLE;
      idx      <= '0;
      last_row <= '0;
      job_c    <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      err      <= 1'b0;
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            if (ds_legal(data_set)) begin
              job_c    <= issue_c;
              last_row <= issue_lastrow;
              idx      <= ADDR_WIDTH'(1);
              busy     <= 1'b1;
              state    <= S_ISSUE;
            end else begin
              done  <= 1'b1;
              err   <= 1'b1;
              state <= S_DONE;
            end
          end
        end
        S_ISSUE: begin
          if (issue_go) begin
            idx <= idx + ADDR_WIDTH'(1);
            if (issue_last) state <= S_DRAIN;
          end
        end
        S_DRAIN: begin
          if (!inflight && count == 2'd0) begin
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= S_DONE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

`ifdef READ_OUT_STALL_CNT_EN
  // Saturating count of cycles where a row waits on the consumer.
  always_ff @(posedge clk) begin
    if (srst || (state == S_IDLE && start)) stall_cnt <= '0;
    else if (out_valid && !out_ready && stall_cnt != 16'hFFFF) stall_cnt <= stall_cnt + 16'd1;
  end
`endif

endmodule

// File: tb/tb_read_out.sv
// Bench for read_out: SRAM models, randomized backpressure, and a
// row-list reference model derived from the data_set mapping rules.
module tb_read_out;

  localparam int AS = 8;
  localparam int OW = 16;
  localparam int AW = 6;
  localparam int DW = AS * OW;

  logic          clk = 1'b0;
  logic          srst;
  logic          start;
  logic [1:0]    data_set;
  logic [AW-1:0] sram_raddr_a, sram_raddr_b, sram_raddr_c;
  logic [DW-1:0] sram_rdata_a, sram_rdata_b, sram_rdata_c;
  logic          out_valid, out_ready, out_last, busy, done, err;
  logic [DW-1:0] out_data;
  logic [AW-1:0] out_index;
`ifdef READ_OUT_STALL_CNT_EN
  logic [15:0]   stall_cnt;
`endif

  logic [DW-1:0] mem_a [64];
  logic [DW-1:0] mem_b [64];
  logic [DW-1:0] mem_c [64];

  assign sram_rdata_a = mem_a[sram_raddr_a];
  assign sram_rdata_b = mem_b[sram_raddr_b];
  assign sram_rdata_c = mem_c[sram_raddr_c];

  always #5 clk = ~clk;

  read_out dut (
    .clk          (clk),
    .srst         (srst),
    .start        (start),
    .data_set     (data_set),
    .sram_raddr_a (sram_raddr_a),
    .sram_rdata_a (sram_rdata_a),
    .sram_raddr_b (sram_raddr_b),
    .sram_rdata_b (sram_rdata_b),
    .sram_raddr_c (sram_raddr_c),
    .sram_rdata_c (sram_rdata_c),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_data     (out_data),
    .out_index    (out_index),
    .out_last     (out_last),
    .busy         (busy),
    .done         (done),
    .err          (err)
`ifdef READ_OUT_STALL_CNT_EN
    ,
    .stall_cnt    (stall_cnt)
`endif
  );

  int vectors = 0;
  int miscompares = 0;

  // Observations collected by drive_job.
  int            q_idx[$];
  logic [DW-1:0] q_data[$];
  bit            q_last[$];
  int done_cyc, n_done, err_cyc, n_err, first_valid, hold_viol, stalls;
  bit ab_nz, c_nz;

  // Reference: the row a job must deliver at position k.
  function automatic logic [DW-1:0] exp_row(input int ds, input int k);
    if (ds == 1) return mem_c[k];
    return (k < AS) ? mem_a[k] : mem_b[k - AS];
  endfunction

  function automatic logic [DW-1:0] rand_row();
    logic [DW-1:0] r;
    for (int i = 0; i < DW / 32; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  task automatic fill_mems(input bit rnd);
    logic [OW-1:0] w;
    for (int k = 0; k < 64; k++) begin
      mem_a[k] = rand_row(); mem_b[k] = rand_row(); mem_c[k] = rand_row();
    end
    if (!rnd) begin
      for (int k = 0; k < AS; k++) begin
        w = 16'h00A0 + 16'(k); mem_a[k] = {AS{w}};
        w = 16'h00B0 + 16'(k); mem_b[k] = {AS{w}};
        w = 16'h8000 + 16'(k); mem_c[k] = {AS{w}};
      end
    end
  endtask

  // Runs one job; cycle k counts clock edges after the start edge.
  task automatic drive_job(input logic [1:0] ds, input int ready_pct, input int restart_cyc);
    logic [DW-1:0] pd; logic [AW-1:0] pi; logic pl; bit hold;
    q_idx.delete(); q_data.delete(); q_last.delete();
    done_cyc = -1; n_done = 0; err_cyc = -1; n_err = 0; first_valid = -1;
    hold_viol = 0; stalls = 0; ab_nz = 0; c_nz = 0; hold = 0;
    pd = '0; pi = '0; pl = 1'b0;
    @(negedge clk);
    start = 1'b1; data_set = ds; out_ready = ($urandom_range(99) < ready_pct);
    for (int k = 1; k <= 400; k++) begin
      @(negedge clk);
      start = (k == restart_cyc);
      if (hold && (!out_valid || out_data !== pd || out_index !== pi || out_last !== pl)) hold_viol++;
      if (out_valid && first_valid < 0) first_valid = k;
      if (sram_raddr_a != 0 || sram_raddr_b != 0) ab_nz = 1;
      if (sram_raddr_c != 0) c_nz = 1;
      if (done) begin n_done++; if (done_cyc < 0) done_cyc = k; end
      if (err) begin n_err++; if (err_cyc < 0) err_cyc = k; end
      out_ready = ($urandom_range(99) < ready_pct);
      if (out_valid && out_ready) begin
        q_idx.push_back(int'(out_index)); q_data.push_back(out_data); q_last.push_back(out_last);
      end
      if (out_valid && !out_ready) stalls++;
      hold = out_valid && !out_ready; pd = out_data; pi = out_index; pl = out_last;
      if (done_cyc >= 0 && k >= done_cyc + 3) break;
    end
    start = 1'b0;
  endtask

  task automatic test_reset();
    srst = 1'b1; start = 1'b0; data_set = 2'd0; out_ready = 1'b0;
    repeat (3) @(negedge clk);
    vectors++;
    if ({out_valid, out_last, busy, done, err} !== 5'b0) begin
      miscompares++; $display("FAIL reset_flags got %b want 00000", {out_valid, out_last, busy, done, err});
    end
    vectors++;
    if (out_data !== '0 || out_index !== '0) begin
      miscompares++; $display("FAIL reset_data got %h/%0d want 0/0", out_data, out_index);
    end
    vectors++;
    if (sram_raddr_a !== '0 || sram_raddr_b !== '0 || sram_raddr_c !== '0) begin
      miscompares++; $display("FAIL reset_raddr got %0d/%0d/%0d want 0/0/0", sram_raddr_a, sram_raddr_b, sram_raddr_c);
    end
    srst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_ab();
    fill_mems(0);
    drive_job(2'd0, 100, -1);
    vectors++;
    if (done_cyc != 19 || n_done != 1) begin
      miscompares++; $display("FAIL ab_done cycle %0d count %0d want 19/1", done_cyc, n_done);
    end
    vectors++;
    if (first_valid != 2) begin
      miscompares++; $display("FAIL ab_first_valid got %0d want 2", first_valid);
    end
    vectors++;
    if (q_idx.size() != 16) begin
      miscompares++; $display("FAIL ab_rows got %0d want 16", q_idx.size());
    end
    for (int i = 0; i < q_idx.size() && i < 16; i++) begin
      vectors++;
      if (q_idx[i] != i || q_data[i] !== exp_row(0, i) || q_last[i] != (i == 15)) begin
        miscompares++;
        $display("FAIL ab_row%0d got idx %0d last %0d data %h want idx %0d last %0d data %h",
                 i, q_idx[i], q_last[i], q_data[i], i, (i == 15), exp_row(0, i));
      end
    end
  endtask

  task automatic test_c();
    fill_mems(0);
    drive_job(2'd1, 100, -1);
    vectors++;
    if (done_cyc != 11 || n_done != 1 || n_err != 0) begin
      miscompares++; $display("FAIL c_done cycle %0d count %0d err %0d want 11/1/0", done_cyc, n_done, n_err);
    end
    vectors++;
    if (ab_nz) begin
      miscompares++; $display("FAIL c_raddr_ab got nonzero want 0");
    end
    vectors++;
    if (q_idx.size() != 8) begin
      miscompares++; $display("FAIL c_rows got %0d want 8", q_idx.size());
    end
    for (int i = 0; i < q_idx.size() && i < 8; i++) begin
      vectors++;
      if (q_idx[i] != i || q_data[i] !== exp_row(1, i) || q_last[i] != (i == 7)) begin
        miscompares++;
        $display("FAIL c_row%0d got idx %0d last %0d data %h want idx %0d last %0d data %h",
                 i, q_idx[i], q_last[i], q_data[i], i, (i == 7), exp_row(1, i));
      end
    end
  endtask

  task automatic test_backpressure();
    for (int rep = 0; rep < 3; rep++) begin
      fill_mems(1);
      drive_job(2'd0, 30, -1);
      vectors++;
      if (n_done != 1 || done_cyc < 19) begin
        miscompares++; $display("FAIL bp_done count %0d cycle %0d want 1/>=19", n_done, done_cyc);
      end
      vectors++;
      if (hold_viol != 0) begin
        miscompares++; $display("FAIL bp_hold violations %0d want 0", hold_viol);
      end
      vectors++;
      if (q_idx.size() != 16) begin
        miscompares++; $display("FAIL bp_rows got %0d want 16", q_idx.size());
      end
      for (int i = 0; i < q_idx.size() && i < 16; i++) begin
        vectors++;
        if (q_idx[i] != i || q_data[i] !== exp_row(0, i) || q_last[i] != (i == 15)) begin
          miscompares++;
          $display("FAIL bp_row%0d got idx %0d last %0d want idx %0d last %0d", i, q_idx[i], q_last[i], i, (i == 15));
        end
      end
`ifdef READ_OUT_STALL_CNT_EN
      vectors++;
      if (int'(stall_cnt) != stalls) begin
        miscompares++; $display("FAIL bp_stall_cnt got %0d want %0d", stall_cnt, stalls);
      end
`endif
    end
  endtask

  task automatic test_illegal();
    for (int ds = 2; ds <= 3; ds++) begin
      drive_job(2'(ds), 100, -1);
      vectors++;
      if (done_cyc != 1 || err_cyc != 1 || n_done != 1 || n_err != 1) begin
        miscompares++;
        $display("FAIL illegal_ds%0d done %0d@%0d err %0d@%0d want 1@1 1@1", ds, n_done, done_cyc, n_err, err_cyc);
      end
      vectors++;
      if (first_valid >= 0 || ab_nz || c_nz || q_idx.size() != 0) begin
        miscompares++;
        $display("FAIL illegal_ds%0d_quiet valid@%0d raddr %0d%0d want no valid, no reads", ds, first_valid, ab_nz, c_nz);
      end
    end
  endtask

  task automatic test_back_to_back();
    fill_mems(1);
    drive_job(2'd0, 100, 5);
    vectors++;
    if (n_done != 1 || done_cyc != 19) begin
      miscompares++; $display("FAIL restart_done count %0d cycle %0d want 1/19", n_done, done_cyc);
    end
    vectors++;
    if (q_idx.size() != 16) begin
      miscompares++; $display("FAIL restart_rows got %0d want 16", q_idx.size());
    end
    for (int i = 0; i < q_idx.size() && i < 16; i++) begin
      vectors++;
      if (q_idx[i] != i || q_data[i] !== exp_row(0, i)) begin
        miscompares++; $display("FAIL restart_row%0d got idx %0d want %0d", i, q_idx[i], i);
      end
    end
  endtask

  task automatic test_abort();
    int accepted; int seen_done;
    fill_mems(1);
    accepted = 0; seen_done = 0;
    @(negedge clk);
    start = 1'b1; data_set = 2'd0; out_ready = 1'b1;
    for (int k = 0; k < 60 && accepted < 6; k++) begin
      @(negedge clk);
      start = 1'b0;
      out_ready = (accepted < 6);
      if (out_valid && out_ready) accepted++;
    end
    @(negedge clk); out_ready = 1'b0;
    repeat (3) @(negedge clk);
    vectors++;
    if (!out_valid || out_index !== AW'(6) || !busy) begin
      miscompares++; $display("FAIL abort_pre valid %0d idx %0d busy %0d want 1/6/1", out_valid, out_index, busy);
    end
    srst = 1'b1;
    @(negedge clk);
    vectors++;
    if (out_valid || busy || done) begin
      miscompares++; $display("FAIL abort_reset valid %0d busy %0d done %0d want 0/0/0", out_valid, busy, done);
    end
    srst = 1'b0;
    repeat (5) begin
      @(negedge clk);
      if (done) seen_done++;
    end
    vectors++;
    if (seen_done != 0 || out_valid) begin
      miscompares++; $display("FAIL abort_quiet done %0d valid %0d want 0/0", seen_done, out_valid);
    end
    drive_job(2'd0, 100, -1);
    vectors++;
    if (q_idx.size() != 16 || done_cyc != 19 || n_done != 1) begin
      miscompares++; $display("FAIL abort_rerun rows %0d done@%0d x%0d want 16 @19 x1", q_idx.size(), done_cyc, n_done);
    end
    for (int i = 0; i < q_idx.size() && i < 16; i++) begin
      vectors++;
      if (q_idx[i] != i || q_data[i] !== exp_row(0, i)) begin
        miscompares++; $display("FAIL abort_row%0d got idx %0d want %0d", i, q_idx[i], i);
      end
    end
  endtask

  initial begin
    test_reset();
    test_ab();
    test_c();
    test_backpressure();
    test_illegal();
    test_back_to_back();
    test_abort();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
